mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle signed multiply/divide responder for the MIPS multicycle datapath. The control unit issues a one-cycle start with operands from the A/B registers. This block then iterates, writes the HI/LO results, and answers with a one-cycle `done` plus a `division_by_zero` flag. The control unit waits in its mult/div state until `done`, then loads the HI and LO registers from `hi_out` and `lo_out`.

## Interface
- `WIDTH`, default 32: operand width. Products and results are 2×WIDTH split into HI/LO.
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start_mult`  in  1  request signed multiply; sampled only in IDLE
- `start_div`  in  1  request signed divide; sampled only in IDLE
- `op_a`  in  WIDTH  multiplicand / dividend; latched on acceptance
- `op_b`  in  WIDTH  multiplier / divisor; latched on acceptance
- `busy`  out  1  high while iterating or fixing sign
- `done`  out  1  one-cycle completion pulse
- `division_by_zero`  out  1  set when a divide is accepted with `op_b`=0
- `hi_out`  out  WIDTH  mult: product[63:32]; div: remainder
- `lo_out`  out  WIDTH  mult: product[31:0]; div: quotient

## Operation
- States: IDLE, MULT, DIV, SIGN, DONE.
- Reset (synchronous, any state):
  - state goes to IDLE.
  - All outputs go to 0: `busy`, `done`, `division_by_zero`, `hi_out`, `lo_out`.
  - Internal iteration counter and work registers are cleared.
- IDLE:
  - `start_mult`=1 → latch the magnitudes of both operands and the result sign (sign_a XOR sign_b), clear the product register, counter=0 → MULT.
  - `start_div`=1 and `op_b`≠0 → latch the magnitudes, quotient sign (sign_a XOR sign_b) and remainder sign (sign_a) → DIV.
  - `start_div`=1 and `op_b`=0 → `division_by_zero`=1, `hi_out`/`lo_out` unchanged → DONE. No iteration.
  - Both starts high at once: multiply wins, divide request dropped.
  - Any accepted start clears `division_by_zero`, except a divide by zero, which sets it.
- MULT: shift-add, one step per cycle, 32 steps.
  - If multiplier bit0=1, add the multiplicand into the upper half of a (2×WIDTH+1)-bit accumulator.
  - Shift accumulator and multiplier right by 1.
  - After step 31 → SIGN.
- DIV: restoring division, one step per cycle, 32 steps.
  - Shift {remainder, dividend} left by 1.
  - Trial subtract = remainder − divisor, computed WIDTH+1 wide.
  - If non-negative, keep the difference and set the new quotient bit to 1; else restore and set it to 0.
  - After step 31 → SIGN.
- SIGN: apply signs and write results.
  - Mult: negate the 64-bit magnitude product if the result sign is set, then `hi_out`/`lo_out` ← product.
  - Div: negate the quotient if the quotient sign is set; negate the remainder if the dividend was negative. Then `lo_out` ← quotient, `hi_out` ← remainder.
  - Quotient truncates toward zero.
  - → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Overflow case: 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps naturally). No flag.
- Start pulses while `busy` or in DONE are ignored; they are not queued.
- Operand inputs may change freely after the acceptance edge.
- `hi_out`, `lo_out` and `division_by_zero` hold their values until the next SIGN write, reset, or start acceptance (the last affects the flag only).

## Timing
- Start sampled high in IDLE at edge E0 (cycle 0).
- Normal operation:
  - `busy`=1 in cycles 1–33: 32 iteration cycles plus 1 SIGN cycle.
  - Results valid and `done`=1 in cycle 34.
  - `busy`=0 during the `done` cycle.
  - A new start is accepted at the earliest at the edge ending cycle 35.
- Divide by zero: `done`=1 and `division_by_zero`=1 in cycle 1; `busy` never asserts.
- `done` and `busy` are never high simultaneously.
- Reset at any point aborts the operation with no `done`. The bench sees all outputs 0 in the following cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Mult 7 × 0xFFFFFFFD (−3): start at cycle 0 → `busy` cycles 1–33, `done` at cycle 34, `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFEB.
- Mult 0x80000000 × 0x80000000 → `hi_out`=0x40000000, `lo_out`=0x00000000. Mult 0xFFFFFFFF × 0xFFFFFFFF → `hi_out`=0, `lo_out`=1.
- Div 0xFFFFFFF9 (−7) / 2 → `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF, `division_by_zero`=0, `done` at cycle 34.
- Div 0x80000000 / 0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0.
- Div 5 / 0 after a prior mult left `hi_out`=0x12, `lo_out`=0x34 → `done` and `division_by_zero`=1 at cycle 1, `hi_out`=0x12, `lo_out`=0x34 unchanged. A following start_mult clears the flag.
- Robustness:
  - Pulse start_div at cycle 5 while busy → ignored; the result of the original op is unchanged.
  - Simultaneous start_mult and start_div → multiply result.
  - `reset` at cycle 10 → no `done`, all outputs 0 at cycle 11, next start accepted normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit producing HI/LO results.
// Shift-add multiply and restoring divide on operand magnitudes, one step per
// cycle, followed by a sign-fixup cycle and a one-cycle done pulse.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             division_by_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StMult, StDiv, StSign, StDone} state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]    cnt_q, cnt_d;
   // a_q: multiplicand magnitude, or dividend shifting out / quotient shifting in
   logic [WIDTH-1:0]   a_q, a_d;
   // b_q: multiplier magnitude shifting right, or divisor magnitude
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_upper;
   logic [2*WIDTH:0]   acc_step;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod_mag, prod_fin;
   logic [WIDTH-1:0]   quo_fin, rem_fin;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; multiply wins when both starts arrive together
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_mult) begin
               state_d = StMult;
            end else if (start_div) begin
               state_d = (op_b == '0) ? StDone : StDiv;
            end
         end
         StMult:  if (cnt_q == LastCnt) state_d = StSign;
         StDiv:   if (cnt_q == LastCnt) state_d = StSign;
         StSign:  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from the next state so they are registered
   always_comb begin
      busy_d = (state_d == StMult) || (state_d == StDiv) || (state_d == StSign);
      done_d = (state_d == StDone);
   end

   // Datapath next-state: operand capture, iteration steps, sign fixup
   always_comb begin
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      is_div_d  = is_div_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;

      abs_a     = op_a[WIDTH-1] ? -op_a : op_a;
      abs_b     = op_b[WIDTH-1] ? -op_b : op_b;

      mul_upper = acc_q[2*WIDTH:WIDTH] + (b_q[0] ? {1'b0, a_q} : '0);
      acc_step  = {mul_upper, acc_q[WIDTH-1:0]};

      // Remainder can exceed WIDTH bits after the shift, so trial is WIDTH+1 wide
      rem_sh    = {rem_q, a_q[WIDTH-1]};
      diff      = rem_sh - {1'b0, b_q};

      prod_mag  = acc_q[2*WIDTH-1:0];
      prod_fin  = neg_res_q ? -prod_mag : prod_mag;
      quo_fin   = neg_res_q ? -a_q : a_q;
      rem_fin   = neg_rem_q ? -rem_q : rem_q;

      unique case (state_q)
         StIdle: begin
            if (start_mult) begin
               a_d       = abs_a;
               b_d       = abs_b;
               neg_res_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
               acc_d     = '0;
               cnt_d     = '0;
               is_div_d  = 1'b0;
               dbz_d     = 1'b0;
            end else if (start_div) begin
               if (op_b == '0) begin
                  dbz_d = 1'b1;
               end else begin
                  a_d       = abs_a;
                  b_d       = abs_b;
                  neg_res_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                  neg_rem_d = op_a[WIDTH-1];
                  rem_d     = '0;
                  cnt_d     = '0;
                  is_div_d  = 1'b1;
                  dbz_d     = 1'b0;
               end
            end
         end
         StMult: begin
            acc_d = acc_step >> 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CntW'(1);
         end
         StDiv: begin
            rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d = cnt_q + CntW'(1);
         end
         StSign: begin
            if (is_div_q) begin
               lo_d = quo_fin;
               hi_d = rem_fin;
            end else begin
               hi_d = prod_fin[2*WIDTH-1:WIDTH];
               lo_d = prod_fin[WIDTH-1:0];
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         is_div_q  <= is_div_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign division_by_zero = dbz_q;
   assign hi_out           = hi_q;
   assign lo_out           = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic        division_by_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int n_checks = 0;
   int n_pass   = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .start_mult       (start_mult),
      .start_div        (start_div),
      .op_a             (op_a),
      .op_b             (op_b),
      .busy             (busy),
      .done             (done),
      .division_by_zero (division_by_zero),
      .hi_out           (hi_out),
      .lo_out           (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one start, then watch up to 40 cycles for done. Cycle 1 is the cycle
   // after the acceptance edge. Returns in the done cycle (sampled at negedge).
   task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input int pulse_cyc,
                         output int done_cyc, output int busy_err, output logic dbz_c1);
      logic is_dbz;
      logic exp_busy;
      is_dbz = !m && d && (b == 32'd0);
      @(negedge clk);
      start_mult = m;
      start_div  = d;
      op_a       = a;
      op_b       = b;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_a       = $urandom;
      op_b       = $urandom;
      done_cyc   = 0;
      busy_err   = 0;
      dbz_c1     = 1'b0;
      for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) dbz_c1 = division_by_zero;
         if (done) done_cyc = cyc;
         exp_busy = !is_dbz && (cyc <= 33);
         if (busy !== exp_busy) busy_err++;
         if (busy && done) busy_err++;
         if (cyc == pulse_cyc) begin
            start_div = 1'b1;
            op_a      = 32'd5;
            op_b      = 32'd1;
         end else begin
            start_div = 1'b0;
         end
      end
      start_div = 1'b0;
   endtask

   int   dc;
   int   be;
   logic d1;
   int   late_done;

   initial begin
      reset      = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_a       = '0;
      op_b       = '0;
      repeat (2) @(negedge clk);
      check("reset_outs", {27'd0, busy, done, division_by_zero, hi_out, lo_out}, 64'd0);
      reset = 1'b0;

      // 7 * -3 = -21
      run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 0, dc, be, d1);
      check("m1_done_cyc", 64'(dc), 64'd34);
      check("m1_busy", 64'(be), 64'd0);
      check("m1_hilo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
      check("m1_dbz", 64'(division_by_zero), 64'd0);
      @(negedge clk);
      check("m1_done_pulse", {62'd0, done, busy}, 64'd0);
      check("m1_hold", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);

      // min * min
      run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 0, dc, be, d1);
      check("m2_done_cyc", 64'(dc), 64'd34);
      check("m2_hilo", {hi_out, lo_out}, 64'h40000000_00000000);

      // -1 * -1
      run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, dc, be, d1);
      check("m3_hilo", {hi_out, lo_out}, 64'h00000000_00000001);

      // -7 / 2 -> q=-3, r=-1
      run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 0, dc, be, d1);
      check("d1_done_cyc", 64'(dc), 64'd34);
      check("d1_busy", 64'(be), 64'd0);
      check("d1_hilo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
      check("d1_dbz", 64'(division_by_zero), 64'd0);

      // Overflow wraps: min / -1
      run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, dc, be, d1);
      check("d2_hilo", {hi_out, lo_out}, 64'h00000000_80000000);

      // 620 * 124692599 = 0x12_00000034
      run_op(1'b1, 1'b0, 32'd620, 32'd124692599, 0, dc, be, d1);
      check("m4_hilo", {hi_out, lo_out}, 64'h00000012_00000034);

      // 5 / 0: immediate done, results held
      run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, dc, be, d1);
      check("dz_done_cyc", 64'(dc), 64'd1);
      check("dz_busy", 64'(be), 64'd0);
      check("dz_flag_c1", 64'(d1), 64'd1);
      check("dz_flag", 64'(division_by_zero), 64'd1);
      check("dz_hold", {hi_out, lo_out}, 64'h00000012_00000034);

      // Following multiply clears the flag on acceptance
      run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, dc, be, d1);
      check("clr_flag_c1", 64'(d1), 64'd0);
      check("clr_hilo", {hi_out, lo_out}, 64'd12);
      check("clr_dbz", 64'(division_by_zero), 64'd0);

      // start_div pulse at cycle 5 while busy is ignored: 100 / 7 = 14 r 2
      run_op(1'b0, 1'b1, 32'd100, 32'd7, 5, dc, be, d1);
      check("pulse_done_cyc", 64'(dc), 64'd34);
      check("pulse_busy", 64'(be), 64'd0);
      check("pulse_hilo", {hi_out, lo_out}, 64'h00000002_0000000E);
      @(negedge clk);
      @(negedge clk);
      check("pulse_no_restart", {62'd0, busy, done}, 64'd0);

      // Both starts: multiply wins, 6 * -2 = -12
      run_op(1'b1, 1'b1, 32'd6, 32'hFFFFFFFE, 0, dc, be, d1);
      check("both_done_cyc", 64'(dc), 64'd34);
      check("both_hilo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFF4);

      // Reset at cycle 10 aborts a multiply
      @(negedge clk);
      start_mult = 1'b1;
      op_a       = 32'd3;
      op_b       = 32'd5;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_outs", {27'd0, busy, done, division_by_zero, hi_out, lo_out}, 64'd0);
      reset     = 1'b0;
      late_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) late_done++;
      end
      check("rst_no_done", 64'(late_done), 64'd0);

      run_op(1'b1, 1'b0, 32'd3, 32'd5, 0, dc, be, d1);
      check("post_rst_done_cyc", 64'(dc), 64'd34);
      check("post_rst_hilo", {hi_out, lo_out}, 64'd15);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
